// File: rtl/hamming_secded_decoder.sv
// Parametrised SECDED Hamming decoder with a two-stage valid/ready pipeline.
// Define HAMMING_DEC_CNT_EN to build the saturating corrected/uncorrectable event counters.
module hamming_secded_decoder #(
  parameter  int DATA_W = 8,
  localparam int P_W    = (DATA_W <= 4)  ? 3 :
                          (DATA_W <= 11) ? 4 :
                          (DATA_W <= 26) ? 5 :
                          (DATA_W <= 57) ? 6 : 7,
  localparam int CODE_W = DATA_W + P_W + 1
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corr,
  output logic              out_uncorr,
  output logic [P_W-1:0]    out_syndrome,
  output logic [15:0]       corr_cnt,
  output logic [15:0]       uncorr_cnt,
  input  logic              cnt_clr
);

  // Codeword index holding data bit j: the j-th non-power-of-two Hamming position, minus one.
  function automatic int data_idx(input int j);
    int n;
    int res;
    n   = 0;
    res = 0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (n == j) res = pos - 1;
        n++;
      end
    end
    return res;
  endfunction

  // ---------------- stage 1: codeword, syndrome, overall parity ----------------
  logic              s1_valid_q, s1_valid_d;
  logic [CODE_W-1:0] s1_code_q,  s1_code_d;
  logic [P_W-1:0]    s1_syn_q,   s1_syn_d;
  logic              s1_g_q,     s1_g_d;

  // ---------------- stage 2: decoded result ----------------
  logic              out_valid_q,  out_valid_d;
  logic [DATA_W-1:0] out_data_q,   out_data_d;
  logic              out_corr_q,   out_corr_d;
  logic              out_uncorr_q, out_uncorr_d;
  logic [P_W-1:0]    out_syn_q,    out_syn_d;

  logic              s2_ready;
  logic [P_W-1:0]    syn_c;
  logic              g_c;
  logic              syn_nz, in_rng, corr_c, uncorr_c;
  logic [CODE_W-1:0] fixed_code;
  logic [DATA_W-1:0] data_c;

  assign s2_ready = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;

  always_comb begin
    syn_c = '0;
    for (int k = 0; k < P_W; k++) begin
      for (int i = 0; i < CODE_W - 1; i++) begin
        if ((((i + 1) >> k) & 1) != 0) syn_c[k] = syn_c[k] ^ in_code[i];
      end
    end
  end

  assign g_c = ^in_code;

  // Out-of-range syndromes with odd overall parity are multi-bit errors that alias as singles.
  always_comb begin
    syn_nz   = |s1_syn_q;
    in_rng   = (int'(s1_syn_q) <= CODE_W - 1);
    corr_c   = s1_g_q && (!syn_nz || in_rng);
    uncorr_c = syn_nz && !(s1_g_q && in_rng);
    fixed_code = s1_code_q;
    if (corr_c && syn_nz) begin
      for (int i = 0; i < CODE_W - 1; i++) begin
        if (int'(s1_syn_q) == i + 1) fixed_code[i] = ~s1_code_q[i];
      end
    end
  end

  for (genvar j = 0; j < DATA_W; j++) begin : g_data
    localparam int IDX = data_idx(j);
    assign data_c[j] = fixed_code[IDX];
  end

  // Parity positions of the corrected word are not part of the payload.
  logic unused_par;
  assign unused_par = ^fixed_code;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_code_d    = s1_code_q;
    s1_syn_d     = s1_syn_q;
    s1_g_d       = s1_g_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_corr_d   = out_corr_q;
    out_uncorr_d = out_uncorr_q;
    out_syn_d    = out_syn_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_code_d = in_code;
        s1_syn_d  = syn_c;
        s1_g_d    = g_c;
      end
    end
    // Stage 2 only loads when it can move, so a stalled result holds every out_* port.
    if (s2_ready) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d   = data_c;
        out_corr_d   = corr_c;
        out_uncorr_d = uncorr_c;
        out_syn_d    = s1_syn_q;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      s1_valid_q   <= 1'b0;
      s1_code_q    <= '0;
      s1_syn_q     <= '0;
      s1_g_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_corr_q   <= 1'b0;
      out_uncorr_q <= 1'b0;
      out_syn_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_code_q    <= s1_code_d;
      s1_syn_q     <= s1_syn_d;
      s1_g_q       <= s1_g_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_corr_q   <= out_corr_d;
      out_uncorr_q <= out_uncorr_d;
      out_syn_q    <= out_syn_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_corr     = out_corr_q;
  assign out_uncorr   = out_uncorr_q;
  assign out_syndrome = out_syn_q;

`ifdef HAMMING_DEC_CNT_EN
  logic        fire;
  logic [15:0] corr_cnt_q,   corr_cnt_d;
  logic [15:0] uncorr_cnt_q, uncorr_cnt_d;

  assign fire = out_valid_q && out_ready;

  // Clear has priority over a same-cycle event; that event is dropped.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (fire) begin
      if (out_corr_q && corr_cnt_q != 16'hFFFF)     corr_cnt_d   = corr_cnt_q + 16'd1;
      if (out_uncorr_q && uncorr_cnt_q != 16'hFFFF) uncorr_cnt_d = uncorr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
`else
  logic unused_clr;
  assign unused_clr = cnt_clr;
  assign corr_cnt   = 16'h0;
  assign uncorr_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed testbench for hamming_secded_decoder (DATA_W=8, CODE_W=13, P_W=4).
// Counter expectations follow HAMMING_DEC_CNT_EN when the bench is built with it.
module tb_hamming_secded_decoder;

  logic        clk = 1'b0;
  logic        arst;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_corr;
  logic        out_uncorr;
  logic [3:0]  out_syndrome;
  logic [15:0] corr_cnt;
  logic [15:0] uncorr_cnt;
  logic        cnt_clr;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cc = 0;
  int exp_uc = 0;

  hamming_secded_decoder #(.DATA_W(8)) dut (
    .clk(clk), .arst(arst),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_corr(out_corr), .out_uncorr(out_uncorr), .out_syndrome(out_syndrome),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    #12;
    n_chk++;
    if ({out_valid, out_data, out_corr, out_uncorr, out_syndrome} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h c=%b u=%b s=%h, expected all 0",
               out_valid, out_data, out_corr, out_uncorr, out_syndrome);
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    n_chk++;
    if (corr_cnt !== 16'h0 || uncorr_cnt !== 16'h0) begin
      n_fail++; $display("FAIL reset_counters: got %h/%h expected 0/0", corr_cnt, uncorr_cnt);
    end
    @(posedge clk); #1;
    arst = 1'b0;
    #1;
  endtask

  // One word at a time: latency, decoded value, flags, syndrome and counter effect.
  task automatic test_decode;
    logic [12:0] codes [7];
    logic [7:0]  edata [7];
    logic [1:0]  eflag [7];   // {corr, uncorr}
    logic [3:0]  esyn  [7];
    codes = '{13'h0A27, 13'h0A07, 13'h1A27, 13'h0807, 13'h1226, 13'h0A26, 13'h0227};
    edata = '{8'hA5,    8'hA5,    8'hA5,    8'h81,    8'h25,    8'hA5,    8'hA5};
    eflag = '{2'b00,    2'b10,    2'b10,    2'b01,    2'b01,    2'b10,    2'b10};
    esyn  = '{4'd0,     4'd6,     4'd0,     4'd12,    4'd13,    4'd1,     4'd12};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_code  = codes[i];
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL decode_early_valid[%0d]: got %b expected 0", i, out_valid);
      end
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== 1'b1) begin
        n_fail++; $display("FAIL decode_latency[%0d]: got out_valid=%b expected 1", i, out_valid);
      end
      n_chk++;
      if (out_data !== edata[i]) begin
        n_fail++; $display("FAIL decode_data[%0d]: got %h expected %h", i, out_data, edata[i]);
      end
      n_chk++;
      if ({out_corr, out_uncorr} !== eflag[i]) begin
        n_fail++; $display("FAIL decode_flags[%0d]: got corr/uncorr=%b%b expected %b", i, out_corr, out_uncorr, eflag[i]);
      end
      n_chk++;
      if (out_syndrome !== esyn[i]) begin
        n_fail++; $display("FAIL decode_syndrome[%0d]: got %0d expected %0d", i, out_syndrome, esyn[i]);
      end
      @(posedge clk); #1;
`ifdef HAMMING_DEC_CNT_EN
      if (eflag[i][1]) exp_cc++;
      if (eflag[i][0]) exp_uc++;
`endif
      n_chk++;
      if (corr_cnt !== 16'(exp_cc) || uncorr_cnt !== 16'(exp_uc)) begin
        n_fail++; $display("FAIL decode_counters[%0d]: got %0d/%0d expected %0d/%0d", i, corr_cnt, uncorr_cnt, exp_cc, exp_uc);
      end
    end
  endtask

  // Full-rate stream: one result per cycle, in order.
  task automatic test_back_to_back;
    logic [12:0] codes [4];
    logic [7:0]  edata [4];
    codes = '{13'h0000, 13'h0F77, 13'h0550, 13'h1007};
    edata = '{8'h00,    8'hFF,    8'h5A,    8'h01};
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = (k < 4);
      if (k < 4) in_code = codes[k];
      #1;
      if (k < 4) begin
        n_chk++;
        if (in_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", k, in_ready);
        end
      end
      @(posedge clk); #1;
      if (k >= 1 && k <= 4) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== edata[k-1]) begin
          n_fail++; $display("FAIL b2b_out[%0d]: got v=%b d=%h expected v=1 d=%h", k-1, out_valid, out_data, edata[k-1]);
        end
      end
    end
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [12:0] codes [4];
    logic [7:0]  edata [4];
    logic [7:0]  got [$];
    int          sent;
    logic        acc;
    codes = '{13'h0A27, 13'h0550, 13'h0F77, 13'h1007};
    edata = '{8'hA5,    8'h5A,    8'hFF,    8'h01};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = codes[0];
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready_w0: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_code = codes[1];
    #1;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_ready_w1: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_code = codes[2];
    // Two words buffered; the head must hold steady while the consumer stalls.
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hA5) begin
        n_fail++; $display("FAIL bp_stall[%0d]: got in_ready=%b v=%b d=%h expected 0/1/a5", c, in_ready, out_valid, out_data);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    sent = 2;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) got.push_back(out_data);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      in_valid = (sent < 4);
      if (sent < 4) in_code = codes[sent];
      #1;
    end
    in_valid = 1'b0;
    n_chk++;
    if (got.size() != 4) begin
      n_fail++; $display("FAIL bp_count: got %0d words expected 4", got.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        n_chk++;
        if (got[i] !== edata[i]) begin
          n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got[i], edata[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_code   = 13'h0A07;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid);
    end
    arst = 1'b1;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_corr !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_outputs: got v=%b c=%b d=%h rdy=%b expected 0/0/00/1", out_valid, out_corr, out_data, in_ready);
    end
    n_chk++;
    if (corr_cnt !== 16'h0 || uncorr_cnt !== 16'h0) begin
      n_fail++; $display("FAIL mid_reset_counters: got %h/%h expected 0/0", corr_cnt, uncorr_cnt);
    end
    exp_cc = 0;
    exp_uc = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    arst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL mid_no_ghost[%0d]: got out_valid=%b expected 0", c, out_valid);
      end
    end
  endtask

  task automatic test_saturation;
    out_ready = 1'b1;
`ifdef HAMMING_DEC_CNT_EN
    in_valid = 1'b1;
    in_code  = 13'h0A07;
    repeat (65540) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (corr_cnt !== 16'hFFFF || uncorr_cnt !== 16'h0) begin
      n_fail++; $display("FAIL sat_hold: got %h/%h expected ffff/0000", corr_cnt, uncorr_cnt);
    end
`endif
    // Clear coincides with a corrected word leaving the pipe.
    in_valid = 1'b1;
    in_code  = 13'h0A07;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b1 || out_corr !== 1'b1) begin
      n_fail++; $display("FAIL clr_setup: got v=%b c=%b expected 1/1", out_valid, out_corr);
    end
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    n_chk++;
    if (corr_cnt !== 16'h0) begin
      n_fail++; $display("FAIL clr_wins: got %h expected 0000", corr_cnt);
    end
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`ifdef HAMMING_DEC_CNT_EN
    exp_cc = 1;
`else
    exp_cc = 0;
`endif
    n_chk++;
    if (corr_cnt !== 16'(exp_cc)) begin
      n_fail++; $display("FAIL clr_recount: got %0d expected %0d", corr_cnt, exp_cc);
    end
  endtask

  initial begin
    arst      = 1'b1;
    in_valid  = 1'b0;
    in_code   = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    test_reset;
    test_decode;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    test_saturation;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
